// File: rtl/uart_loop_arb.sv
// UART loopback/arbiter: pops RX bytes to rout, echoes them through a small buffer with optional
// CR->CRLF expansion, and round-robins echo and local send channels into the TX FIFO.
module uart_loop_arb #(
  parameter int unsigned DW    = 8,
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CRLF  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     echo_en,
  output logic                     rx_rden,
  input  logic [DW-1:0]            rx_rdata,
  input  logic                     rx_fifo_dvalid,
  output logic [DW-1:0]            rout,
  output logic                     rout_en,
  input  logic [NCH-1:0]           send_req,
  input  logic [NCH*DW-1:0]        send_data,
  output logic [NCH-1:0]           send_ack,
  output logic [DW-1:0]            tx_wdata,
  output logic                     tx_wten,
  input  logic                     tx_fifo_full,
  output logic [$clog2(DEPTH):0]   echo_level
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned RW   = $clog2(NCH + 1);
  localparam int          NReq = int'(NCH) + 1;
  localparam logic [DW-1:0] LfByte = DW'(8'h0A);
  localparam logic [DW-1:0] CrByte = DW'(8'h0D);
  localparam logic [AW:0]   FullLvl = (AW + 1)'(DEPTH);

  typedef enum logic [0:0] {StEcho, StLf} echo_st_e;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  echo_st_e      st_q, st_d;
  logic [RW-1:0] rr_q, rr_d, grant;
  logic          echo_full, echo_empty, pending_lf;
  logic          push, pop, any_req, found;
  logic [NReq-1:0] req;
  logic [DW-1:0]   req_data [NReq];
  logic [DW-1:0]   head;

  assign echo_full  = (level_q == FullLvl);
  assign echo_empty = (level_q == '0);
  assign pending_lf = (st_q == StLf);
  assign head       = mem_q[rd_ptr_q];
  assign echo_level = level_q;

  // A full buffer only stalls RX while echoing; the check uses registered occupancy (no bypass).
  assign rx_rden = ~rst & rx_fifo_dvalid & ~(echo_en & echo_full);
  assign push    = rx_rden & echo_en;

  always_comb begin
    req         = '0;
    req[0]      = pending_lf | ~echo_empty;
    req_data[0] = pending_lf ? LfByte : head;
    for (int i = 0; i < int'(NCH); i++) begin
      req[i+1]      = send_req[i];
      req_data[i+1] = send_data[i*DW +: DW];
    end
  end

  // Round-robin: first requester at or after rr_q, else wrap to the lowest requester.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    any_req = |req;
    for (int j = 0; j < NReq; j++) begin
      if (!found && req[j] && (RW'(j) >= rr_q)) begin
        found = 1'b1;
        grant = RW'(j);
      end
    end
    for (int j = 0; j < NReq; j++) begin
      if (!found && req[j]) begin
        found = 1'b1;
        grant = RW'(j);
      end
    end
  end

  assign tx_wten  = ~rst & any_req & ~tx_fifo_full;
  assign tx_wdata = any_req ? req_data[grant] : '0;
  assign pop      = tx_wten & (grant == '0) & ~pending_lf;

  always_comb begin
    send_ack = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      send_ack[i] = tx_wten && (grant == RW'(i + 1));
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (tx_wten) begin
      rr_d = (grant == RW'(NCH)) ? '0 : grant + RW'(1);
    end
  end

  always_comb begin
    st_d = st_q;
    if (tx_wten && (grant == '0)) begin
      unique case (st_q)
        StEcho:  if ((CRLF != 0) && (head == CrByte)) st_d = StLf;
        StLf:    st_d = StEcho;
        default: st_d = StEcho;
      endcase
    end
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      st_q     <= StEcho;
      rr_q     <= '0;
      rout     <= '0;
      rout_en  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      st_q    <= st_d;
      rr_q    <= rr_d;
      if (rx_rden) rout <= rx_rdata;
      rout_en <= rx_rden;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_rdata;
  end

endmodule
